// File: rtl/bg_fg_classifier_if.sv
// Pixel-in / SRAM-read / result-out bundle for bg_fg_classifier.
// Signal names keep the block's i_/o_ prefixes as seen from the classifier.
//   master : environment side (pixel source, SRAM arbiter, result sink)
//   slave  : classifier side
interface bg_fg_classifier_if;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DQ_W   = 16;

  // pixel input
  logic              i_valid;
  logic              o_ready;
  logic [PIX_W-1:0]  i_gray;
  logic              i_sof;
  logic              i_stats_valid;
  // SRAM read port (shared through an external arbiter)
  logic              o_sram_rd;
  logic [ADDR_W-1:0] o_sram_addr;
  logic              i_sram_gnt;
  logic [DQ_W-1:0]   i_sram_dq;
  // result output
  logic              o_valid;
  logic              i_ready;
  logic              o_fg;
  logic [PIX_W-1:0]  o_gray;
  logic [PIX_W-1:0]  o_mean;

  modport master (
    output i_valid, i_gray, i_sof, i_stats_valid, i_sram_gnt, i_sram_dq, i_ready,
    input  o_ready, o_sram_rd, o_sram_addr, o_valid, o_fg, o_gray, o_mean
  );

  modport slave (
    input  i_valid, i_gray, i_sof, i_stats_valid, i_sram_gnt, i_sram_dq, i_ready,
    output o_ready, o_sram_rd, o_sram_addr, o_valid, o_fg, o_gray, o_mean
  );
endinterface

// File: rtl/bg_fg_classifier.sv
// Foreground/background classifier.
// For each accepted grayscale pixel, reads the pixel's two background stat
// words from SRAM, derives mean and variance, and emits an fg decision.
// Ports:
//   i_clk   : 100 MHz SRAM-side clock
//   i_rst_n : asynchronous active-low reset
//   bus     : pixel in (valid/ready, gray, sof, stats_valid),
//             SRAM read (rd/addr held until gnt, dq one cycle after grant),
//             result out (valid/ready, fg, gray, mean)
module bg_fg_classifier #(
  parameter int unsigned H_MAX       = 640,
  parameter int unsigned V_MAX       = 480,
  parameter int unsigned LOG2_FRAMES = 5,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned K2_Q2       = 36,
  parameter int unsigned MIN_DIFF    = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bg_fg_classifier_if.slave  bus
);

  localparam int unsigned HW     = (H_MAX > 1) ? $clog2(H_MAX) : 1;
  localparam int unsigned VW     = (V_MAX > 1) ? $clog2(V_MAX) : 1;
  localparam int unsigned PW     = ((H_MAX * V_MAX) > 1) ? $clog2(H_MAX * V_MAX) : 1;
  localparam int unsigned AW     = 20;
  localparam int unsigned DW     = 16;
  localparam int unsigned GW     = 8;
  localparam int unsigned SUM_W  = 13;
  localparam int unsigned SQ_W   = 21;
  localparam int unsigned CMP_W  = 24;

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_W0, S_RD1, S_W1, S_CALC, S_OUT
  } state_e;

  state_e            state_q, state_d;
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [PW-1:0]     p_q, p_d;
  logic [GW-1:0]     gray_q, gray_d;
  logic [DW-1:0]     w0_q, w0_d;
  logic [DW-1:0]     w1_q, w1_d;

  logic              ready_q, ready_d;
  logic              rd_q, rd_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              valid_q, valid_d;
  logic              fg_q, fg_d;
  logic [GW-1:0]     ogray_q, ogray_d;
  logic [GW-1:0]     mean_q, mean_d;

  logic              accept_c;
  logic [HW-1:0]     h_cur_c;
  logic [VW-1:0]     v_cur_c;
  logic [PW-1:0]     p_cur_c;

  logic [SUM_W-1:0]  sum_c;
  logic [SQ_W-1:0]   sumsq_c;
  logic [GW-1:0]     mean_c;
  logic [DW-1:0]     ex2_c;
  logic [DW-1:0]     msq_c;
  logic [DW-1:0]     var_c;
  logic [GW-1:0]     d_c;
  logic [DW-1:0]     d2_c;
  logic [CMP_W-1:0]  lhs_c;
  logic [CMP_W-1:0]  rhs_c;
  logic              fg_c;

  // Raster position of the pixel being offered; sof restarts the frame.
  always_comb begin : idx_calc
    accept_c = bus.i_valid && ready_q;
    h_cur_c  = bus.i_sof ? '0 : h_q;
    v_cur_c  = bus.i_sof ? '0 : v_q;
    p_cur_c  = PW'(v_cur_c) * PW'(H_MAX) + PW'(h_cur_c);
  end

  // Mean/variance from the stat pair; both words drop the sum LSBs, hence the appended zero.
  always_comb begin : stats_calc
    sum_c   = {w1_q[11:0], 1'b0};
    sumsq_c = {w0_q, w1_q[15:12], 1'b0};
    mean_c  = GW'(sum_c >> LOG2_FRAMES);
    ex2_c   = DW'(sumsq_c >> LOG2_FRAMES);
    msq_c   = DW'(mean_c) * DW'(mean_c);
    var_c   = (ex2_c >= msq_c) ? (ex2_c - msq_c) : '0;
    d_c     = (gray_q >= mean_c) ? (gray_q - mean_c) : (mean_c - gray_q);
    d2_c    = DW'(d_c) * DW'(d_c);
    // 4*d^2 > (k^2 in Q2)*var, i.e. d > k*sigma without a square root
    lhs_c   = CMP_W'(d2_c) << 2;
    rhs_c   = CMP_W'(K2_Q2) * CMP_W'(var_c);
    fg_c    = (d_c >= GW'(MIN_DIFF)) && (lhs_c > rhs_c);
  end

  // Next-state and next-output logic; outputs are registered from state_d.
  always_comb begin : fsm_comb
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    p_d     = p_q;
    gray_d  = gray_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    fg_d    = fg_q;
    ogray_d = ogray_q;
    mean_d  = mean_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          p_d     = p_cur_c;
          gray_d  = bus.i_gray;
          ogray_d = bus.i_gray;
          if (h_cur_c == HW'(H_MAX - 1)) begin
            h_d = '0;
            v_d = (v_cur_c == VW'(V_MAX - 1)) ? '0 : v_cur_c + VW'(1);
          end else begin
            h_d = h_cur_c + HW'(1);
            v_d = v_cur_c;
          end
          if (bus.i_stats_valid) begin
            state_d = S_RD0;
          end else begin
            // no trained background yet: report background with zero mean
            fg_d    = 1'b0;
            mean_d  = '0;
            state_d = S_OUT;
          end
        end
      end
      S_RD0:  if (bus.i_sram_gnt) state_d = S_W0;
      S_W0: begin
        w0_d    = bus.i_sram_dq;
        state_d = S_RD1;
      end
      S_RD1:  if (bus.i_sram_gnt) state_d = S_W1;
      S_W1: begin
        w1_d    = bus.i_sram_dq;
        state_d = S_CALC;
      end
      S_CALC: begin
        fg_d    = fg_c;
        mean_d  = mean_c;
        state_d = S_OUT;
      end
      S_OUT:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    rd_d    = (state_d == S_RD0) || (state_d == S_RD1);
    valid_d = (state_d == S_OUT);
    if (state_d == S_RD0) begin
      addr_d = AW'(BASE_ADDR) + AW'({p_d, 1'b0});
    end else if (state_d == S_RD1) begin
      addr_d = AW'(BASE_ADDR) + AW'({p_d, 1'b1});
    end else begin
      addr_d = addr_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : fsm_seq
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      p_q     <= '0;
      gray_q  <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
      ready_q <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      fg_q    <= 1'b0;
      ogray_q <= '0;
      mean_q  <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      p_q     <= p_d;
      gray_q  <= gray_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
      ready_q <= ready_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      fg_q    <= fg_d;
      ogray_q <= ogray_d;
      mean_q  <= mean_d;
    end
  end

  assign bus.o_ready     = ready_q;
  assign bus.o_sram_rd   = rd_q;
  assign bus.o_sram_addr = addr_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_fg        = fg_q;
  assign bus.o_gray      = ogray_q;
  assign bus.o_mean      = mean_q;

endmodule

// File: tb/tb_bg_fg_classifier.sv
// Directed bench for bg_fg_classifier: table of single-pixel vectors plus
// hand sequences for stalls, mid-operation reset and frame wrap.
// A second instance with a 4x3 frame runs in lockstep to exercise wrap.
module tb_bg_fg_classifier;

  logic clk;
  logic rst_n;

  bg_fg_classifier_if m();
  bg_fg_classifier_if s();

  bg_fg_classifier dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (m)
  );

  bg_fg_classifier #(.H_MAX(4), .V_MAX(3), .BASE_ADDR(100)) dut_s (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (s)
  );

  // small instance sees exactly the same stimulus
  assign s.i_valid       = m.i_valid;
  assign s.i_gray        = m.i_gray;
  assign s.i_sof         = m.i_sof;
  assign s.i_stats_valid = m.i_stats_valid;
  assign s.i_sram_gnt    = m.i_sram_gnt;
  assign s.i_sram_dq     = m.i_sram_dq;
  assign s.i_ready       = m.i_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] w0_val;
  logic [15:0] w1_val;
  logic [19:0] log_m[$];
  logic [19:0] log_s[$];

  // SRAM model: data returned the cycle after a granted read, word parity selects the word.
  always @(posedge clk) begin
    if (m.o_sram_rd && m.i_sram_gnt) begin
      m.i_sram_dq <= m.o_sram_addr[0] ? w1_val : w0_val;
      log_m.push_back(m.o_sram_addr);
    end
    if (s.o_sram_rd && s.i_sram_gnt) log_s.push_back(s.o_sram_addr);
  end

  typedef struct {
    logic [7:0]  gray;
    logic        sof;
    logic        stats;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        fg;
    logic [7:0]  mean;
    int          nrd;
    logic [19:0] a0;
    int          lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Offer one pixel in idle, then wait (bounded) for o_valid.
  task automatic send(input logic [7:0] g, input logic sf, input logic st, output int lat);
    chk("ready_in_idle", m.o_ready, 1);
    m.i_valid = 1'b1; m.i_gray = g; m.i_sof = sf; m.i_stats_valid = st;
    @(posedge clk); #1;
    m.i_valid = 1'b0; m.i_sof = 1'b0;
    lat = 0;
    while (!m.o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    int p;

    vecs[0]  = '{8'd200, 1'b1, 1'b0, 16'd0,     16'd0,     1'b0, 8'd0,   0, 20'd0,  0};
    vecs[1]  = '{8'd115, 1'b0, 1'b1, 16'd10016, 16'd1600,  1'b1, 8'd100, 2, 20'd2,  5};
    vecs[2]  = '{8'd115, 1'b1, 1'b1, 16'd10016, 16'd1600,  1'b1, 8'd100, 2, 20'd0,  5};
    vecs[3]  = '{8'd110, 1'b0, 1'b1, 16'd10016, 16'd1600,  1'b0, 8'd100, 2, 20'd2,  5};
    vecs[4]  = '{8'd105, 1'b0, 1'b1, 16'd10016, 16'd1600,  1'b0, 8'd100, 2, 20'd4,  5};
    vecs[5]  = '{8'd120, 1'b0, 1'b1, 16'd9000,  16'd1600,  1'b1, 8'd100, 2, 20'd6,  5};
    vecs[6]  = '{8'd100, 1'b0, 1'b1, 16'd9000,  16'd1600,  1'b0, 8'd100, 2, 20'd8,  5};
    vecs[7]  = '{8'd80,  1'b0, 1'b1, 16'd10016, 16'd1600,  1'b1, 8'd100, 2, 20'd10, 5};
    vecs[8]  = '{8'd80,  1'b0, 1'b1, 16'd2600,  16'hF320,  1'b0, 8'd50,  2, 20'd12, 5};
    vecs[9]  = '{8'd81,  1'b0, 1'b1, 16'd2600,  16'hF320,  1'b1, 8'd50,  2, 20'd14, 5};
    vecs[10] = '{8'd0,   1'b0, 1'b1, 16'hFFFF,  16'h0FFF,  1'b1, 8'd255, 2, 20'd16, 5};
    vecs[11] = '{8'd90,  1'b0, 1'b0, 16'd10016, 16'd1600,  1'b0, 8'd0,   0, 20'd0,  0};

    m.i_valid = 1'b0; m.i_gray = '0; m.i_sof = 1'b0; m.i_stats_valid = 1'b0;
    m.i_sram_gnt = 1'b1; m.i_ready = 1'b1;
    w0_val = '0; w1_val = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", m.o_ready, 1);
    chk("rst_rd",    m.o_sram_rd, 0);
    chk("rst_addr",  m.o_sram_addr, 0);
    chk("rst_valid", m.o_valid, 0);
    chk("rst_fg",    m.o_fg, 0);
    chk("rst_gray",  m.o_gray, 0);
    chk("rst_mean",  m.o_mean, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // table vectors
    for (int i = 0; i < NV; i++) begin
      w0_val = vecs[i].w0; w1_val = vecs[i].w1;
      log_m.delete();
      send(vecs[i].gray, vecs[i].sof, vecs[i].stats, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_fg", i),      m.o_fg, vecs[i].fg);
      chk($sformatf("v%0d_mean", i),    m.o_mean, vecs[i].mean);
      chk($sformatf("v%0d_gray", i),    m.o_gray, vecs[i].gray);
      chk($sformatf("v%0d_ready_busy", i), m.o_ready, 0);
      chk($sformatf("v%0d_nreads", i),  log_m.size(), vecs[i].nrd);
      if (vecs[i].nrd == 2 && log_m.size() == 2) begin
        chk($sformatf("v%0d_addr0", i), log_m[0], vecs[i].a0);
        chk($sformatf("v%0d_addr1", i), log_m[1], vecs[i].a0 + 20'd1);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_drop", i), m.o_valid, 0);
    end

    // grant stall then result backpressure, with input changing meanwhile
    w0_val = 16'd10016; w1_val = 16'd1600;
    log_m.delete();
    m.i_sram_gnt = 1'b0; m.i_ready = 1'b0;
    chk("bp_ready_idle", m.o_ready, 1);
    m.i_valid = 1'b1; m.i_gray = 8'd115; m.i_sof = 1'b1; m.i_stats_valid = 1'b1;
    @(posedge clk); #1;
    m.i_valid = 1'b0; m.i_sof = 1'b0; m.i_gray = 8'd7; m.i_stats_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_rd", k),    m.o_sram_rd, 1);
      chk($sformatf("stall%0d_addr", k),  m.o_sram_addr, 0);
      chk($sformatf("stall%0d_ready", k), m.o_ready, 0);
      @(posedge clk); #1;
    end
    m.i_sram_gnt = 1'b1;
    lat = 0;
    while (!m.o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_latency", lat, 5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("hold%0d_valid", k), m.o_valid, 1);
      chk($sformatf("hold%0d_fg", k),    m.o_fg, 1);
      chk($sformatf("hold%0d_mean", k),  m.o_mean, 100);
      chk($sformatf("hold%0d_gray", k),  m.o_gray, 115);
      chk($sformatf("hold%0d_ready", k), m.o_ready, 0);
      @(posedge clk); #1;
    end
    chk("stall_nreads", log_m.size(), 2);
    if (log_m.size() == 2) begin
      chk("stall_addr0", log_m[0], 0);
      chk("stall_addr1", log_m[1], 1);
    end
    m.i_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", m.o_valid, 0);
    chk("bp_release_ready", m.o_ready, 1);

    // reset while waiting for the second read (pixel index 1)
    log_m.delete();
    m.i_valid = 1'b1; m.i_gray = 8'd115; m.i_sof = 1'b0; m.i_stats_valid = 1'b1;
    @(posedge clk); #1;
    m.i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rd1_rd",   m.o_sram_rd, 1);
    chk("rd1_addr", m.o_sram_addr, 3);
    m.i_sram_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd",    m.o_sram_rd, 0);
    chk("async_rst_valid", m.o_valid, 0);
    chk("async_rst_ready", m.o_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    m.i_sram_gnt = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (m.o_valid || m.o_sram_rd) seen = 1'b1;
    end
    chk("abandoned_no_output", seen, 0);
    log_m.delete();
    send(8'd115, 1'b0, 1'b1, lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_fg", m.o_fg, 1);
    chk("post_rst_nreads", log_m.size(), 2);
    if (log_m.size() == 2) chk("post_rst_addr0", log_m[0], 0);
    @(posedge clk); #1;

    // frame wrap on the 4x3 instance (base 100)
    w0_val = 16'd10016; w1_val = 16'd1600;
    for (int k = 0; k < 13; k++) begin
      log_s.delete();
      send(8'd115, (k == 0), 1'b1, lat);
      p = k % 12;
      chk($sformatf("wrap%0d_nreads", k), log_s.size(), 2);
      if (log_s.size() == 2) begin
        chk($sformatf("wrap%0d_addr0", k), log_s[0], 100 + 2 * p);
        chk($sformatf("wrap%0d_addr1", k), log_s[1], 101 + 2 * p);
      end
      chk($sformatf("wrap%0d_valid", k), s.o_valid, 1);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
